// File: rtl/tetris_pkg.sv
// Shared types, VGA 640x480@60 timing constants and the colour palette for the
// Tetris playfield renderer and the game-logic block.
package tetris_pkg;

    typedef logic [2:0]  cell_t;
    typedef logic [9:0]  coord_t;
    typedef logic [11:0] rgb_t;

    localparam int GRID_W = 10;
    localparam int GRID_H = 22;

    // grid[col][row]; row 0 is the top spawn row
    typedef cell_t [GRID_W-1:0][GRID_H-1:0] grid_t;

    // Horizontal timing in pixel clocks; *_SYNC_END is exclusive
    localparam coord_t H_ACTIVE     = 10'd640;
    localparam coord_t H_SYNC_START = 10'd656;
    localparam coord_t H_SYNC_END   = 10'd752;
    localparam coord_t H_TOTAL      = 10'd800;

    // Vertical timing in lines; *_SYNC_END is exclusive
    localparam coord_t V_ACTIVE     = 10'd480;
    localparam coord_t V_SYNC_START = 10'd490;
    localparam coord_t V_SYNC_END   = 10'd492;
    localparam coord_t V_TOTAL      = 10'd525;

    localparam rgb_t GRID_LINE_RGB = 12'h444;

    // One pixel's worth of state between pipeline stage 1 and stage 2
    typedef struct packed {
        logic  in_board;
        logic  grid_line;
        cell_t code;
        logic  hsync;
        logic  vsync;
        logic  vde;
    } pix_s1_t;

    localparam pix_s1_t PIX_S1_RESET = '{
        in_board:  1'b0,
        grid_line: 1'b0,
        code:      3'd0,
        hsync:     1'b1,
        vsync:     1'b1,
        vde:       1'b0
    };

    // Cell code to RGB444; code 0 is the dark-grey empty-cell background
    function automatic rgb_t palette(input cell_t code);
        case (code)
            3'd1:    return 12'h0FF;
            3'd2:    return 12'hFF0;
            3'd3:    return 12'hF0F;
            3'd4:    return 12'h0F0;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            3'd7:    return 12'hF80;
            default: return 12'h222;
        endcase
    endfunction

endpackage

// File: rtl/tetris_grid_renderer_timing.sv
// vga_timing_gen: free-running 800x525 raster counters with raw (unpipelined)
// sync and active-video flags for 640x480@60.
module vga_timing_gen
    import tetris_pkg::*;
(
    input  logic   clk,
    input  logic   Reset,
    output coord_t hc,
    output coord_t vc,
    output logic   hsync_raw,
    output logic   vsync_raw,
    output logic   vde_raw
);

    coord_t hc_q, hc_d;
    coord_t vc_q, vc_d;

    // Next raster position: hc wraps every line, vc advances on that wrap
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_TOTAL - 10'd1) begin
            hc_d = '0;
            vc_d = (vc_q == V_TOTAL - 10'd1) ? '0 : vc_q + 10'd1;
        end
    end

    // Raster counter registers; reset restarts the frame at the top-left pixel
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (Reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc        = hc_q;
    assign vc        = vc_q;
    assign hsync_raw = !((hc_q >= H_SYNC_START) && (hc_q < H_SYNC_END));
    assign vsync_raw = !((vc_q >= V_SYNC_START) && (vc_q < V_SYNC_END));
    assign vde_raw   = (hc_q < H_ACTIVE) && (vc_q < V_ACTIVE);

endmodule

// File: rtl/tetris_grid_renderer.sv
// tetris_grid_renderer: snapshots the 10x22 playfield once per frame and
// renders it as VGA RGB444 with a fixed 2-cycle counter-to-pixel latency.
// Optional build macro GRIDLINES_EN draws a 1-pixel grid over the board.
module tetris_grid_renderer
    import tetris_pkg::*;
#(
    parameter int CELL_PX     = 16,
    parameter int ORIGIN_X    = 240,
    parameter int ORIGIN_Y    = 80,
    parameter int HIDDEN_ROWS = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  grid_t      grid,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       vde,
    output logic       frame_start
);

    localparam int     CELL_SH = $clog2(CELL_PX);
    localparam coord_t BX0     = coord_t'(ORIGIN_X);
    localparam coord_t BX1     = coord_t'(ORIGIN_X + GRID_W * CELL_PX);
    localparam coord_t BY0     = coord_t'(ORIGIN_Y);
    localparam coord_t BY1     = coord_t'(ORIGIN_Y + (GRID_H - HIDDEN_ROWS) * CELL_PX);

`ifdef GRIDLINES_EN
    localparam coord_t CELL_MASK = coord_t'(CELL_PX - 1);
    localparam coord_t DX_LAST   = BX1 - BX0 - 10'd1;
    localparam coord_t DY_LAST   = BY1 - BY0 - 10'd1;
`endif

    // ---------------- S0: raster counters ----------------
    coord_t hc, vc;
    logic   hsync_raw, vsync_raw, vde_raw;

    vga_timing_gen u_timing (
        .clk       (clk),
        .Reset     (Reset),
        .hc        (hc),
        .vc        (vc),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .vde_raw   (vde_raw)
    );

    // Snapshot on the first blanking line so the visible frame never tears
    logic  snap_take;
    grid_t snap_q, snap_d;

    assign snap_take   = !Reset && (hc == '0) && (vc == V_ACTIVE);
    assign frame_start = snap_take;
    assign snap_d      = snap_take ? grid : snap_q;

    // Board snapshot register, cleared on reset so a fresh frame shows an empty board
    always_ff @(posedge clk) begin
        // NOTE: the snapshot is reset deliberately; large storage normally is not, but here the post-reset picture must be empty.
        if (Reset) snap_q <= '0;
        else       snap_q <= snap_d;
    end

    // ---------------- S1: board hit test and cell lookup ----------------
    logic    in_board;
    coord_t  dx, dy;
    logic [3:0] col;
    logic [4:0] row;
    pix_s1_t s1_d, s1_q;

    // Map the raster position onto a board cell; offsets stay zero off-board
    always_comb begin
        in_board = (hc >= BX0) && (hc < BX1) && (vc >= BY0) && (vc < BY1);
        dx       = in_board ? hc - BX0 : '0;
        dy       = in_board ? vc - BY0 : '0;
        col      = 4'(dx >> CELL_SH);
        row      = 5'(dy >> CELL_SH) + 5'(HIDDEN_ROWS);

        s1_d          = PIX_S1_RESET;
        s1_d.in_board = in_board;
        s1_d.code     = in_board ? snap_q[col][row] : '0;
        s1_d.hsync    = hsync_raw;
        s1_d.vsync    = vsync_raw;
        s1_d.vde      = vde_raw;
`ifdef GRIDLINES_EN
        // Left/top pixel of every cell, plus the board's last column and row
        s1_d.grid_line = in_board && (((dx & CELL_MASK) == '0) || ((dy & CELL_MASK) == '0) ||
                                      (dx == DX_LAST) || (dy == DY_LAST));
`else
        s1_d.grid_line = 1'b0;
`endif
    end

    // Stage-1 pipeline register
    always_ff @(posedge clk) begin
        if (Reset) s1_q <= PIX_S1_RESET;
        else       s1_q <= s1_d;
    end

    // ---------------- S2: palette and blanking ----------------
    rgb_t rgb_d, rgb_q;
    logic hsync_q, vsync_q, vde_q;

    // Colour the pixel; black outside the board and during blanking
    always_comb begin
        rgb_d = '0;
        if (s1_q.vde && s1_q.in_board) begin
            rgb_d = s1_q.grid_line ? GRID_LINE_RGB : palette(s1_q.code);
        end
    end

    // Stage-2 output registers keep sync/vde aligned with the colour
    always_ff @(posedge clk) begin
        if (Reset) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            vde_q   <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= s1_q.hsync;
            vsync_q <= s1_q.vsync;
            vde_q   <= s1_q.vde;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign hsync              = hsync_q;
    assign vsync              = vsync_q;
    assign vde                = vde_q;

endmodule

// File: tb/tb_tetris_grid_renderer.sv
// Directed bench for tetris_grid_renderer. Pixel expectations follow the
// GRIDLINES_EN macro so the same file checks both builds.
`timescale 1ns/1ps
module tb_tetris_grid_renderer;
    import tetris_pkg::*;

    localparam int FRAME = 800 * 525;

`ifdef GRIDLINES_EN
    localparam rgb_t E_240_80  = 12'h444;
    localparam rgb_t E_256_80  = 12'h444;
    localparam rgb_t E_399_399 = 12'h444;
`else
    localparam rgb_t E_240_80  = 12'h0FF;
    localparam rgb_t E_256_80  = 12'h222;
    localparam rgb_t E_399_399 = 12'hF00;
`endif

    logic       clk = 1'b0;
    logic       Reset;
    grid_t      grid;
    logic [3:0] red, green, blue;
    logic       hsync, vsync, vde, frame_start;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int orange_n = 0;

    always #2 clk = ~clk;

    tetris_grid_renderer dut (
        .clk         (clk),
        .Reset       (Reset),
        .grid        (grid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .vde         (vde),
        .frame_start (frame_start)
    );

    // Watch for any orange pixel leaking out of the hidden spawn rows
    always @(negedge clk) begin
        if (!Reset && {red, green, blue} == 12'hF80) orange_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge where cyc == t (cyc counts posedges since release)
    task automatic run_to(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Pixel (x,y) of the frame starting at base appears 2 cycles after its count
    task automatic pix(input string tag, input int base, input int x, input int y, input rgb_t exp);
        run_to(base + y * 800 + x + 2);
        check(tag, 32'({red, green, blue}), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"},   32'({red, green, blue}), 32'h0);
        check({tag, "_hsync"}, 32'(hsync), 32'h1);
        check({tag, "_vsync"}, 32'(vsync), 32'h1);
        check({tag, "_vde"},   32'(vde), 32'h0);
        check({tag, "_fs"},    32'(frame_start), 32'h0);
    endtask

    initial begin
        int found;
        int fs_n;
        int fs_at;

        // Board contents present before any snapshot
        grid       = '0;
        grid[0][2] = 3'd1;
        grid[9][21] = 3'd5;
        grid[0][0] = 3'd7;
        Reset      = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst_hold");

        // Release; first hsync low 656 + 2 cycles later
        Reset = 1'b0;
        cyc   = 0;
        found = 0;
        while (cyc < 1000 && found == 0) begin
            @(negedge clk);
            cyc++;
            if (hsync === 1'b0) found = cyc;
        end
        check("first_hsync_low", 32'(found), 32'd658);

        // Frame 0 displays the empty reset snapshot although grid is populated
        pix("f0_240_80_empty", 0, 240, 80, 12'h222);

        // Abort mid-frame at vc=300 with a one-cycle reset pulse
        run_to(300 * 800 + 300);
        check("pre_reset_vde", 32'(vde), 32'h1);
        Reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_pulse");
        Reset = 1'b0;
        cyc   = 0;

        // Exactly one frame_start, at hc=0 vc=480 after the release
        fs_n  = 0;
        fs_at = 0;
        while (cyc < 384010) begin
            @(negedge clk);
            cyc++;
            if (frame_start === 1'b1) begin
                fs_n++;
                fs_at = cyc;
            end
        end
        check("fs_count", 32'(fs_n), 32'd1);
        check("fs_cycle", 32'(fs_at), 32'd384000);

        // Frame 1: snapshot contents visible, in raster order
        check("hsync_655", 32'(0), 32'(0) | 32'(0));
        pix("f1_dummy_order", FRAME, 0, 0, 12'h000);
        run_to(FRAME + 10 * 800 + 655 + 2);
        check("hsync_655_high", 32'(hsync), 32'h1);
        run_to(FRAME + 10 * 800 + 656 + 2);
        check("hsync_656_low", 32'(hsync), 32'h0);
        run_to(FRAME + 10 * 800 + 751 + 2);
        check("hsync_751_low", 32'(hsync), 32'h0);
        run_to(FRAME + 10 * 800 + 752 + 2);
        check("hsync_752_high", 32'(hsync), 32'h1);

        pix("f1_239_80_outside", FRAME, 239, 80, 12'h000);
        pix("f1_240_80", FRAME, 240, 80, E_240_80);
        pix("f1_256_80", FRAME, 256, 80, E_256_80);
        pix("f1_241_81", FRAME, 241, 81, 12'h0FF);
        pix("f1_255_95", FRAME, 255, 95, 12'h0FF);

        // Change the board at vc=100; this frame must not see it
        run_to(FRAME + 100 * 800);
        grid[9][21] = 3'd2;

        run_to(FRAME + 100 * 800 + 639 + 2);
        check("vde_639", 32'(vde), 32'h1);
        run_to(FRAME + 100 * 800 + 640 + 2);
        check("vde_640", 32'(vde), 32'h0);

        pix("f1_398_398_old", FRAME, 398, 398, 12'hF00);
        pix("f1_399_399", FRAME, 399, 399, E_399_399);
        pix("f1_400_399_outside", FRAME, 400, 399, 12'h000);

        // Vertical sync window
        run_to(FRAME + 489 * 800 + 2);
        check("vsync_489_high", 32'(vsync), 32'h1);
        run_to(FRAME + 490 * 800 + 2);
        check("vsync_490_low", 32'(vsync), 32'h0);
        run_to(FRAME + 492 * 800 + 2);
        check("vsync_492_high", 32'(vsync), 32'h1);
        check("hidden_row_orange", 32'(orange_n), 32'd0);

        // Frame 2 shows the change taken by the frame-1 snapshot
        pix("f2_398_398_new", 2 * FRAME, 398, 398, 12'hFF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
